// File: rtl/noc_cfg_scheduler_pkg.sv
// noc_cfg_scheduler_pkg: shared types and helpers for the NoC config scheduler.
// Holds the per-processor FSM encoding, processor count and a sizing helper.
package noc_cfg_scheduler_pkg;

  localparam int NUM_PROC = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } cfg_state_e;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/noc_cfg_scheduler_if.sv
// noc_cfg_scheduler_if: host command port (valid/ready, target, word).
// master = host side, slave = scheduler side.
interface noc_cfg_scheduler_if #(
  parameter int CFG_W = 11
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_proc;
  logic [CFG_W-1:0] cmd_word;

  modport master (
    output cmd_valid, cmd_proc, cmd_word,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_proc, cmd_word,
    output cmd_ready
  );
endinterface

// File: rtl/noc_cfg_scheduler_rr_arb.sv
// noc_cfg_rr_arb: 4-way round-robin arbiter, scan starts at rr_ptr.
// Ports: req[3:0], rr_ptr[1:0] in; one-hot grant[3:0] out.
module noc_cfg_rr_arb (
  input  logic [3:0] req,
  input  logic [1:0] rr_ptr,
  output logic [3:0] grant
);

  logic [1:0] idx;

  always_comb begin
    grant = '0;
    idx   = '0;
    for (int j = 0; j < 4; j++) begin
      idx = rr_ptr + 2'(j);
      if (grant == '0 && req[idx]) begin
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_cfg_scheduler.sv
// noc_cfg_scheduler: host words -> p0..p3_configure, one launch per cycle,
// round-robin to ready processors; each word held HOLD_CYCLES then
// GAP_CYCLES of zero.
// Ports: clock, reset (async high), cmd (slave if), processor_ready_signals,
// p0..p3_configure, busy, done_pulse, err_timeout (NOC_CFG_TIMEOUT_EN only).
// Optional macro NOC_CFG_TIMEOUT_EN: drop words pending too long on a
// not-ready processor and flag err_timeout.
module noc_cfg_scheduler
  import noc_cfg_scheduler_pkg::*;
#(
  parameter int CFG_W          = 11,
  parameter int HOLD_CYCLES    = 6,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clock,
  input  logic             reset,
  noc_cfg_scheduler_if.slave cmd,
  input  logic [3:0]       processor_ready_signals,
  output logic [CFG_W-1:0] p0_configure,
  output logic [CFG_W-1:0] p1_configure,
  output logic [CFG_W-1:0] p2_configure,
  output logic [CFG_W-1:0] p3_configure,
  output logic [3:0]       busy,
  output logic [3:0]       done_pulse
`ifdef NOC_CFG_TIMEOUT_EN
  ,
  output logic [3:0]       err_timeout
`endif
);

  localparam int CNT_W =
    $clog2(max3(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
`ifdef NOC_CFG_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [3:0] to_drop;
`endif

  logic [3:0]       pend_v_q, pend_v_d;
  logic [CFG_W-1:0] pend_w_q [NUM_PROC];
  logic [CFG_W-1:0] pend_w_d [NUM_PROC];
  logic [1:0]       rr_q, rr_d;
  logic [3:0]       req, grant;
  logic [CFG_W-1:0] cfg_out [NUM_PROC];
  logic             acc_ok;

  assign acc_ok        = !pend_v_q[cmd.cmd_proc];
  assign cmd.cmd_ready = acc_ok;

  noc_cfg_rr_arb u_arb (
    .req    (req),
    .rr_ptr (rr_q),
    .grant  (grant)
  );

  // Grant frees the slot; a zero word is taken but never stored.
  always_comb begin
    pend_v_d = pend_v_q;
    pend_w_d = pend_w_q;
    rr_d     = rr_q;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (grant[i]) begin
        pend_v_d[i] = 1'b0;
        rr_d        = 2'(i + 1);
      end
    end
`ifdef NOC_CFG_TIMEOUT_EN
    pend_v_d = pend_v_d & ~to_drop;
`endif
    if (cmd.cmd_valid && acc_ok && cmd.cmd_word != '0) begin
      pend_v_d[cmd.cmd_proc] = 1'b1;
      pend_w_d[cmd.cmd_proc] = cmd.cmd_word;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_v_q <= '0;
      rr_q     <= '0;
      for (int i = 0; i < NUM_PROC; i++) pend_w_q[i] <= '0;
    end else begin
      pend_v_q <= pend_v_d;
      rr_q     <= rr_d;
      pend_w_q <= pend_w_d;
    end
  end

  for (genvar i = 0; i < NUM_PROC; i++) begin : g_proc
    cfg_state_e       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic             done_q, done_d;

    assign req[i] = (st_q == ST_IDLE) && pend_v_q[i]
                    && processor_ready_signals[i];

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      cfg_d  = cfg_q;
      done_d = 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          if (grant[i]) begin
            st_d  = ST_DRIVE;
            cfg_d = pend_w_q[i];
            cnt_d = HOLD_LD;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == '0) begin
            st_d   = ST_GAP;
            cfg_d  = '0;
            done_d = 1'b1;
            cnt_d  = GAP_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) st_d = ST_IDLE;
          else cnt_d = cnt_q - CNT_W'(1);
        end
        default: st_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        st_q   <= ST_IDLE;
        cnt_q  <= '0;
        cfg_q  <= '0;
        done_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        cfg_q  <= cfg_d;
        done_q <= done_d;
      end
    end

    assign busy[i]       = (st_q != ST_IDLE);
    assign done_pulse[i] = done_q;
    assign cfg_out[i]    = cfg_q;

`ifdef NOC_CFG_TIMEOUT_EN
    // Wait count restarts whenever the stall condition breaks.
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             err_q, err_d;
    logic             wait_c;

    assign wait_c     = pend_v_q[i] && (st_q == ST_IDLE)
                        && !processor_ready_signals[i];
    assign to_drop[i] = wait_c && (wait_q == TO_LD);
    assign wait_d     = (wait_c && !to_drop[i]) ?
                        wait_q + CNT_W'(1) : '0;
    assign err_d      = err_q | to_drop[i];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wait_q <= '0;
        err_q  <= 1'b0;
      end else begin
        wait_q <= wait_d;
        err_q  <= err_d;
      end
    end

    assign err_timeout[i] = err_q;
`endif
  end

  assign p0_configure = cfg_out[0];
  assign p1_configure = cfg_out[1];
  assign p2_configure = cfg_out[2];
  assign p3_configure = cfg_out[3];

endmodule
